// File: rtl/chi_xp_link_ctrl.sv
// chi_xp_link_ctrl: per-port CHI link activation FSMs and L-credit counters.
// Optional handshake timeout when CHI_XP_LINK_TIMEOUT_EN is defined.
module chi_xp_link_ctrl #(
  parameter int NUM_PORTS      = 2,
  parameter int NUM_CH         = 4,
  parameter int MAX_CRD        = 15,
  parameter int RX_BUF_DEPTH   = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CRD_W          = $clog2(MAX_CRD+1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        link_en,
  output logic [NUM_PORTS-1:0]        TXLINKACTIVEREQ,
  input  logic [NUM_PORTS-1:0]        TXLINKACTIVEACK,
  input  logic [NUM_PORTS-1:0]        RXLINKACTIVEREQ,
  output logic [NUM_PORTS-1:0]        RXLINKACTIVEACK,
  output logic [NUM_PORTS-1:0]        TXSACTIVE,
  input  logic [NUM_PORTS*NUM_CH-1:0] tx_lcrdv,
  input  logic [NUM_PORTS*NUM_CH-1:0] tx_flit_sent,
  output logic [NUM_PORTS*NUM_CH-1:0] tx_crd_avail,
  output logic [NUM_PORTS*NUM_CH-1:0] tx_crd_ret_req,
  input  logic [NUM_PORTS*NUM_CH-1:0] rx_flitv,
  input  logic [NUM_PORTS*NUM_CH-1:0] rx_buf_free,
  output logic [NUM_PORTS*NUM_CH-1:0] RXLCRDV,
`ifdef CHI_XP_LINK_TIMEOUT_EN
  output logic [NUM_PORTS-1:0]        crd_err,
  output logic [NUM_PORTS-1:0]        link_timeout
`else
  output logic [NUM_PORTS-1:0]        crd_err
`endif
);

  localparam logic [CRD_W-1:0] CMAX = CRD_W'(MAX_CRD);
  localparam logic [CRD_W-1:0] CDEP = CRD_W'(RX_BUF_DEPTH);
  localparam logic [CRD_W:0]   PMAX = (CRD_W+1)'(MAX_CRD);

  typedef enum logic [1:0] {
    ST_STOP, ST_ACT, ST_RUN, ST_DEACT
  } st_t;

  if (RX_BUF_DEPTH > MAX_CRD || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("chi_xp_link_ctrl: bad parameters");
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    st_t tx_st, rx_st;
    logic tx_req, rx_ack, tx_sact, err_q;
    logic en, tx_ack, rx_req;
    logic tx_to_stop, rx_run_nx;
    logic [NUM_CH-1:0] ch_err, outs_nz;

    assign en      = link_en[p];
    assign tx_ack  = TXLINKACTIVEACK[p];
    assign rx_req  = RXLINKACTIVEREQ[p];

    assign tx_to_stop = (tx_st == ST_DEACT) && !tx_ack;
    // Grants are issued on the edge that lands in (or stays in) RUN.
    assign rx_run_nx  = (rx_st == ST_ACT) ||
                        (rx_st == ST_RUN && rx_req);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        tx_st   <= ST_STOP;
        tx_req  <= 1'b0;
        tx_sact <= 1'b0;
      end else begin
        tx_sact <= (tx_st != ST_STOP) || en;
        unique case (tx_st)
          ST_STOP:
            if (en && !tx_ack) begin
              tx_st  <= ST_ACT;
              tx_req <= 1'b1;
            end
          ST_ACT:
            if (tx_ack) tx_st <= ST_RUN;
          ST_RUN:
            if (!en) begin
              tx_st  <= ST_DEACT;
              tx_req <= 1'b0;
            end
          ST_DEACT:
            if (!tx_ack) tx_st <= ST_STOP;
        endcase
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rx_st  <= ST_STOP;
        rx_ack <= 1'b0;
      end else begin
        unique case (rx_st)
          ST_STOP:
            if (rx_req) begin
              rx_st  <= ST_ACT;
              rx_ack <= 1'b1;
            end
          ST_ACT:
            rx_st <= ST_RUN;
          ST_RUN:
            if (!rx_req) rx_st <= ST_DEACT;
          ST_DEACT:
            if (outs_nz == '0) begin
              rx_st  <= ST_STOP;
              rx_ack <= 1'b0;
            end
        endcase
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= err_q | (|ch_err);
    end

    assign TXLINKACTIVEREQ[p] = tx_req;
    assign RXLINKACTIVEACK[p] = rx_ack;
    assign TXSACTIVE[p]       = tx_sact;
    assign crd_err[p]         = err_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      localparam int I = p*NUM_CH + c;
      logic [CRD_W-1:0] tx_cnt, tx_nx;
      logic [CRD_W-1:0] pend, outs;
      logic [CRD_W:0]   pend_sum;
      logic tx_inc, tx_dec, tx_err;
      logic grant, grant_q, flit_ok, lcrd_ret;

      assign tx_inc = tx_lcrdv[I] && (tx_st != ST_STOP);
      assign tx_dec = tx_flit_sent[I];

      always_comb begin
        tx_nx  = tx_cnt;
        tx_err = 1'b0;
        if (tx_inc && !tx_dec) begin
          if (tx_cnt == CMAX) tx_err = 1'b1;
          else                tx_nx  = tx_cnt + 1'b1;
        end else if (tx_dec && !tx_inc) begin
          if (tx_cnt == '0) tx_err = 1'b1;
          else              tx_nx  = tx_cnt - 1'b1;
        end
        if (tx_to_stop) tx_nx = '0;
      end

      assign grant   = rx_run_nx && (pend != '0);
      assign flit_ok = rx_flitv[I] && (outs != '0);
      // Flits seen while RX deactivates are LCrdReturns: slot not used.
      assign lcrd_ret = flit_ok && (rx_st == ST_DEACT);
      assign pend_sum = {1'b0, pend}
                      - (CRD_W+1)'(grant)
                      + (CRD_W+1)'(rx_buf_free[I])
                      + (CRD_W+1)'(lcrd_ret);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          tx_cnt  <= '0;
          pend    <= CDEP;
          outs    <= '0;
          grant_q <= 1'b0;
        end else begin
          tx_cnt  <= tx_nx;
          pend    <= (pend_sum > PMAX) ? CMAX
                                       : pend_sum[CRD_W-1:0];
          outs    <= outs + CRD_W'(grant) - CRD_W'(flit_ok);
          grant_q <= grant;
        end
      end

      assign ch_err[c]  = tx_err || (rx_flitv[I] && outs == '0);
      assign outs_nz[c] = (outs != '0);

      assign tx_crd_avail[I]   = (tx_st == ST_RUN) && (tx_cnt != '0);
      assign tx_crd_ret_req[I] = (tx_st == ST_DEACT) && (tx_cnt != '0);
      assign RXLCRDV[I]        = grant_q;
    end

`ifdef CHI_XP_LINK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES+1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);
    logic [TW-1:0] to_cnt;
    logic to_q, tx_chg, rx_chg, to_run;

    assign tx_chg = (tx_st == ST_STOP && en && !tx_ack) ||
                    (tx_st == ST_ACT && tx_ack) ||
                    (tx_st == ST_RUN && !en) ||
                    tx_to_stop;
    assign rx_chg = (rx_st == ST_STOP && rx_req) ||
                    (rx_st == ST_ACT) ||
                    (rx_st == ST_RUN && !rx_req) ||
                    (rx_st == ST_DEACT && outs_nz == '0);
    assign to_run = (tx_st == ST_ACT) || (tx_st == ST_DEACT) ||
                    (rx_st == ST_DEACT);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        to_cnt <= '0;
        to_q   <= 1'b0;
      end else if (tx_chg || rx_chg) begin
        to_cnt <= '0;
      end else if (to_run) begin
        if (to_cnt != TMAX)       to_cnt <= to_cnt + 1'b1;
        if (to_cnt == TMAX - 1'b1) to_q  <= 1'b1;
      end else begin
        to_cnt <= '0;
      end
    end

    assign link_timeout[p] = to_q;
`endif
  end

endmodule

// File: tb/tb_chi_xp_link_ctrl.sv
// tb_chi_xp_link_ctrl: directed and randomized bench checked against a
// behavioural model of the link activation and L-credit rules.
`timescale 1ns/1ps
module tb_chi_xp_link_ctrl;
  localparam int NP   = 2;
  localparam int NC   = 4;
  localparam int NPC  = NP*NC;
  localparam int MAXC = 15;
  localparam int DEP  = 4;
  localparam int TO   = 16;
  localparam int STOP = 0, ACT = 1, RUN = 2, DEACT = 3;

  logic clk = 1'b0;
  logic rst;
  logic [NP-1:0]  link_en, txreq, txack, rxreq, rxack, txsact, crd_err;
  logic [NPC-1:0] tx_lcrdv, tx_flit_sent, tx_crd_avail, tx_crd_ret_req;
  logic [NPC-1:0] rx_flitv, rx_buf_free, rxlcrdv;
`ifdef CHI_XP_LINK_TIMEOUT_EN
  logic [NP-1:0]  link_timeout;
`endif

  always #5 clk = ~clk;

  chi_xp_link_ctrl #(
    .NUM_PORTS(NP), .NUM_CH(NC), .MAX_CRD(MAXC),
    .RX_BUF_DEPTH(DEP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .link_en(link_en),
    .TXLINKACTIVEREQ(txreq), .TXLINKACTIVEACK(txack),
    .RXLINKACTIVEREQ(rxreq), .RXLINKACTIVEACK(rxack),
    .TXSACTIVE(txsact),
    .tx_lcrdv(tx_lcrdv), .tx_flit_sent(tx_flit_sent),
    .tx_crd_avail(tx_crd_avail), .tx_crd_ret_req(tx_crd_ret_req),
    .rx_flitv(rx_flitv), .rx_buf_free(rx_buf_free),
    .RXLCRDV(rxlcrdv),
    .crd_err(crd_err)
`ifdef CHI_XP_LINK_TIMEOUT_EN
    , .link_timeout(link_timeout)
`endif
  );

  // Reference model: link phases, credit pools and buffer occupancy.
  int m_tx[NP], m_rx[NP], m_to[NP];
  int m_cnt[NP][NC], m_pend[NP][NC], m_out[NP][NC], m_occ[NP][NC];
  bit m_err[NP], m_tout[NP], m_sact[NP], m_grant[NP][NC];
  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      m_tx[p] = STOP; m_rx[p] = STOP; m_to[p] = 0;
      m_err[p] = 0; m_tout[p] = 0; m_sact[p] = 0;
      for (int c = 0; c < NC; c++) begin
        m_cnt[p][c] = 0; m_pend[p][c] = DEP;
        m_out[p][c] = 0; m_occ[p][c] = 0; m_grant[p][c] = 0;
      end
    end
  endtask

  task automatic model_step();
    for (int p = 0; p < NP; p++) begin
      int otx, orx, ntx, nrx;
      bit all0;
      otx = m_tx[p]; orx = m_rx[p];
      all0 = 1;
      for (int c = 0; c < NC; c++) if (m_out[p][c] != 0) all0 = 0;
      m_sact[p] = (otx != STOP) || link_en[p];
      ntx = otx;
      case (otx)
        STOP:    if (link_en[p] && !txack[p]) ntx = ACT;
        ACT:     if (txack[p]) ntx = RUN;
        RUN:     if (!link_en[p]) ntx = DEACT;
        default: if (!txack[p]) ntx = STOP;
      endcase
      nrx = orx;
      case (orx)
        STOP:    if (rxreq[p]) nrx = ACT;
        ACT:     nrx = RUN;
        RUN:     if (!rxreq[p]) nrx = DEACT;
        default: if (all0) nrx = STOP;
      endcase
      for (int c = 0; c < NC; c++) begin
        int i;
        bit inc, dec;
        i = p*NC + c;
        inc = tx_lcrdv[i] && (otx != STOP);
        dec = tx_flit_sent[i];
        if (inc && !dec) begin
          if (m_cnt[p][c] == MAXC) m_err[p] = 1;
          else m_cnt[p][c]++;
        end else if (dec && !inc) begin
          if (m_cnt[p][c] == 0) m_err[p] = 1;
          else m_cnt[p][c]--;
        end
        if (otx == DEACT && ntx == STOP) m_cnt[p][c] = 0;
        m_grant[p][c] = 0;
        if (nrx == RUN && m_pend[p][c] > 0) begin
          m_grant[p][c] = 1;
          m_pend[p][c]--;
          m_out[p][c]++;
        end
        if (rx_flitv[i]) begin
          if (m_out[p][c] == 0) m_err[p] = 1;
          else begin
            m_out[p][c]--;
            if (orx == DEACT) m_pend[p][c]++;
            else m_occ[p][c]++;
          end
        end
        if (rx_buf_free[i]) begin
          m_pend[p][c]++;
          if (m_occ[p][c] > 0) m_occ[p][c]--;
        end
        if (m_pend[p][c] > MAXC) m_pend[p][c] = MAXC;
      end
      if (ntx != otx || nrx != orx) m_to[p] = 0;
      else if (otx == ACT || otx == DEACT || orx == DEACT) begin
        if (m_to[p] < TO) m_to[p]++;
        if (m_to[p] == TO) m_tout[p] = 1;
      end else m_to[p] = 0;
      m_tx[p] = ntx; m_rx[p] = nrx;
    end
  endtask

  task automatic check_all(input string tag);
    logic [NP-1:0]  e_req, e_ack, e_sact, e_err, e_to;
    logic [NPC-1:0] e_av, e_ret, e_lv;
    for (int p = 0; p < NP; p++) begin
      e_req[p]  = (m_tx[p] == ACT) || (m_tx[p] == RUN);
      e_ack[p]  = (m_rx[p] != STOP);
      e_sact[p] = m_sact[p];
      e_err[p]  = m_err[p];
      e_to[p]   = m_tout[p];
      for (int c = 0; c < NC; c++) begin
        e_av[p*NC+c]  = (m_tx[p] == RUN) && (m_cnt[p][c] > 0);
        e_ret[p*NC+c] = (m_tx[p] == DEACT) && (m_cnt[p][c] > 0);
        e_lv[p*NC+c]  = m_grant[p][c];
      end
    end
    check({tag, ".txreq"}, 32'(txreq), 32'(e_req));
    check({tag, ".rxack"}, 32'(rxack), 32'(e_ack));
    check({tag, ".txsactive"}, 32'(txsact), 32'(e_sact));
    check({tag, ".crd_err"}, 32'(crd_err), 32'(e_err));
    check({tag, ".avail"}, 32'(tx_crd_avail), 32'(e_av));
    check({tag, ".ret_req"}, 32'(tx_crd_ret_req), 32'(e_ret));
    check({tag, ".rxlcrdv"}, 32'(rxlcrdv), 32'(e_lv));
`ifdef CHI_XP_LINK_TIMEOUT_EN
    check({tag, ".timeout"}, 32'(link_timeout), 32'(e_to));
`else
    if (e_to === 'x) check({tag, ".timeout"}, 0, 1);
`endif
  endtask

  task automatic clr_pulses();
    tx_lcrdv = '0; tx_flit_sent = '0;
    rx_flitv = '0; rx_buf_free = '0;
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
    clr_pulses();
  endtask

  task automatic do_reset(input string tag);
    link_en = '0; txack = '0; rxreq = '0;
    clr_pulses();
    rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ng;
    link_en = '0; txack = '0; rxreq = '0;
    clr_pulses();
    rst = 1'b1;
    #12;
    model_reset();
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Bring-up of port 0 TX
    link_en[0] = 1'b1;
    tick("bu");
    check("bu_req_c1", 32'(txreq[0]), 1);
    tick("bu"); tick("bu");
    txack[0] = 1'b1;
    tick("bu_ack");
    check("bu_avail0", 32'(tx_crd_avail[3:0]), 0);
    repeat (4) begin tx_lcrdv[3:0] = 4'hF; tick("bu_crd"); end
    check("bu_avail", 32'(tx_crd_avail[3:0]), 32'hF);

    // RX credit issue on port 1
    rxreq[1] = 1'b1;
    tick("rx_up");
    check("rx_ack", 32'(rxack[1]), 1);
    check("rx_nogrant_act", 32'(rxlcrdv[7:4]), 0);
    ng = 0;
    repeat (6) begin
      tick("rx_grant");
      if (rxlcrdv[7:4] == 4'hF) ng++;
    end
    check("rx_grants", 32'(ng), 4);
    check("rx_grant_stop", 32'(rxlcrdv[7:4]), 0);
    repeat (2) begin rx_flitv[7:4] = 4'hF; tick("rx_flit"); end
    rx_buf_free[4] = 1'b1;
    tick("rx_free");
    tick("rx_regrant");
    check("rx_free_regrant", 32'(rxlcrdv[7:4]), 1);
    rx_flitv[4] = 1'b1;
    tick("rx_flit");

    // TX teardown on port 0 with three credits left
    tx_flit_sent[3:0] = 4'hF;
    tick("td_use");
    link_en[0] = 1'b0;
    tick("td");
    check("td_req", 32'(txreq[0]), 0);
    check("td_ret", 32'(tx_crd_ret_req[3:0]), 32'hF);
    repeat (3) begin tx_flit_sent[3:0] = 4'hF; tick("td_ret"); end
    check("td_ret_done", 32'(tx_crd_ret_req[3:0]), 0);
    txack[0] = 1'b0;
    tick("td_stop");
    tick("td_stop");
    check("td_sact", 32'(txsact[0]), 0);

    // RX teardown on port 1 with two outstanding per channel
    rxreq[1] = 1'b0;
    tick("rtd");
    check("rtd_ack_hold", 32'(rxack[1]), 1);
    rx_flitv[7:4] = 4'hF;
    tick("rtd_f1");
    check("rtd_ack_f1", 32'(rxack[1]), 1);
    rx_flitv[7:4] = 4'hF;
    tick("rtd_f2");
    check("rtd_ack_f2", 32'(rxack[1]), 1);
    check("rtd_nogrant", 32'(rxlcrdv[7:4]), 0);
    tick("rtd_stop");
    check("rtd_ack_low", 32'(rxack[1]), 0);

    // Simultaneous credit events and underflow
    do_reset("rst1");
    link_en[0] = 1'b1; tick("e_up");
    txack[0] = 1'b1;   tick("e_up");
    tx_lcrdv[2] = 1'b1; tick("e_crd");
    tx_lcrdv[2] = 1'b1; tx_flit_sent[2] = 1'b1;
    tick("e_both");
    check("sim_avail", 32'(tx_crd_avail[2]), 1);
    tx_flit_sent[2] = 1'b1; tick("e_use");
    check("sim_empty", 32'(tx_crd_avail[2]), 0);
    check("sim_noerr", 32'(crd_err[0]), 0);
    tx_flit_sent[3] = 1'b1; tick("e_under");
    check("underflow_err", 32'(crd_err[0]), 1);
    do_reset("midrun_rst");
    check("midrun_err_clr", 32'(crd_err), 0);

    // Overflow: 16th credit saturates at 15
    link_en[0] = 1'b1; tick("o_up");
    txack[0] = 1'b1;   tick("o_up");
    repeat (15) begin tx_lcrdv[1] = 1'b1; tick("o_crd"); end
    check("ovf_noerr15", 32'(crd_err[0]), 0);
    tx_lcrdv[1] = 1'b1; tick("o_16");
    check("ovf_err", 32'(crd_err[0]), 1);
    repeat (14) begin tx_flit_sent[1] = 1'b1; tick("o_use"); end
    check("ovf_sat_14", 32'(tx_crd_avail[1]), 1);
    tx_flit_sent[1] = 1'b1; tick("o_use");
    check("ovf_sat_15", 32'(tx_crd_avail[1]), 0);
    do_reset("rst2");

    // Randomized traffic with a legal peer
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset("rand_rst");
      for (int p = 0; p < NP; p++) begin
        bit mreq;
        mreq = (m_tx[p] == ACT) || (m_tx[p] == RUN);
        if ($urandom_range(0, 39) == 0) link_en[p] = ~link_en[p];
        if (txack[p] != mreq && $urandom_range(0, 2) == 0)
          txack[p] = mreq;
        if (!rxreq[p] && m_rx[p] == STOP && $urandom_range(0, 9) == 0)
          rxreq[p] = 1'b1;
        else if (rxreq[p] && m_rx[p] == RUN &&
                 $urandom_range(0, 39) == 0)
          rxreq[p] = 1'b0;
        for (int c = 0; c < NC; c++) begin
          int i;
          i = p*NC + c;
          tx_lcrdv[i] = (m_tx[p] != STOP) && (m_cnt[p][c] < MAXC) &&
                        ($urandom_range(0, 2) == 0);
          tx_flit_sent[i] = (m_cnt[p][c] > 0) &&
                            ($urandom_range(0, 2) == 0);
          rx_flitv[i] = (m_out[p][c] > 0) &&
                        ($urandom_range(0, 2) == 0);
          rx_buf_free[i] = (m_occ[p][c] > 0) &&
                           ($urandom_range(0, 3) == 0);
        end
      end
      tick("rand");
    end

`ifdef CHI_XP_LINK_TIMEOUT_EN
    // Peer never acknowledges
    do_reset("to_rst");
    link_en[0] = 1'b1;
    tick("to_act");
    repeat (15) tick("to_wait");
    check("to_early", 32'(link_timeout[0]), 0);
    tick("to_hit");
    check("to_set", 32'(link_timeout[0]), 1);
    tick("to_sticky");
    check("to_sticky", 32'(link_timeout[0]), 1);
    do_reset("to_clr");
    check("to_clr", 32'(link_timeout), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
